// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encoding, line-select codes and line-select helper for the UART transmitter
//   state_t      one-hot FSM state (6 bits)
//   line_sel_t   source of the serial line level (START/DATA/PARITY/STOP)
//   line_sel()   maps an FSM state to the line source it drives
package uart_tx_pkg;
   typedef enum logic [5:0] {
      ST_IDLE   = 6'b000001,
      ST_START  = 6'b000010,
      ST_DATA   = 6'b000100,
      ST_PARITY = 6'b001000,
      ST_STOP1  = 6'b010000,
      ST_STOP2  = 6'b100000
   } state_t;
   typedef enum logic [1:0] {
      LS_START,
      LS_DATA,
      LS_PARITY,
      LS_STOP
   } line_sel_t;
   function automatic line_sel_t line_sel(input state_t s);
      return s == ST_START  ? LS_START  :
             s == ST_DATA   ? LS_DATA   :
             s == ST_PARITY ? LS_PARITY : LS_STOP;
   endfunction
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: data shift register and bit counter for the UART transmitter
//   CLK       bit-rate clock
//   RST       asynchronous active-low reset
//   load      capture din and clear the bit counter
//   shift_en  consume bit_out, shift right, count one bit
//   din       character to serialize
//   bit_out   next data bit to put on the line (LSB first)
//   done      all DATA_W bits have been consumed
module uart_tx_serializer #(
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              load,
   input  logic              shift_en,
   input  logic [DATA_W-1:0] din,
   output logic              bit_out,
   output logic              done
);
   localparam int CW = $clog2(DATA_W + 1);
   logic [DATA_W-1:0] sh;
   logic [CW-1:0]     cnt;
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         sh  <= '0;
         cnt <= '0;
      end else if (load) begin
         sh  <= din;
         cnt <= '0;
      end else if (shift_en) begin
         sh  <= sh >> 1;
         cnt <= cnt + 1'b1;
      end
   assign bit_out = sh[0];
   assign done    = cnt == CW'(DATA_W);
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmit FSM with optional parity and one or two stop bits
//   CLK         bit-rate clock, one line bit per cycle
//   RST         asynchronous active-low reset
//   P_DATA      character to send (DATA_W bits)
//   DATA_VALID  send request, accepted in IDLE or in the last stop cycle
//   PAR_EN      append a parity bit
//   PAR_TYP     0 = even parity, 1 = odd parity
//   STOP2       two stop bits (honoured only when UART_TX_STOP2_EN is defined)
//   TX_OUT      registered serial line
//   BUSY        registered, high from START through the last stop bit
//   DATA_ACK    registered, high during the START cycle
// Build option: define UART_TX_STOP2_EN to build the second stop state.
module uart_tx_engine
   import uart_tx_pkg::*;
#(
   parameter int   DATA_W   = 8,
   parameter logic IDLE_LVL = 1'b1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] P_DATA,
   input  logic              DATA_VALID,
   input  logic              PAR_EN,
   input  logic              PAR_TYP,
   input  logic              STOP2,
   output logic              TX_OUT,
   output logic              BUSY,
   output logic              DATA_ACK
);
   state_t    state, nxt;
   line_sel_t sel;
   logic      ser_bit, ser_done, shift_en, last_stop, accept, tx_d;
   logic      par_en_q, par_bit_q;
`ifdef UART_TX_STOP2_EN
   logic stop2_q;
   assign last_stop = state == ST_STOP2 || (state == ST_STOP1 && !stop2_q);
   always_ff @(posedge CLK or negedge RST)
      if (!RST) stop2_q <= 1'b0;
      else if (accept) stop2_q <= STOP2;
`else
   logic unused_stop2;
   assign unused_stop2 = STOP2;
   assign last_stop    = state == ST_STOP1;
`endif
   assign accept = DATA_VALID && (state == ST_IDLE || last_stop);
   // The line and status registers are loaded from the next state so they
   // change on the same edge as the state itself.
   always_comb begin
      nxt = ST_IDLE;
      if (accept) nxt = ST_START;
      else if (!last_stop)
         case (state)
            ST_START:  nxt = ST_DATA;
            ST_DATA:   nxt = ser_done ? (par_en_q ? ST_PARITY : ST_STOP1) : ST_DATA;
            ST_PARITY: nxt = ST_STOP1;
            ST_STOP1:  nxt = ST_STOP2;
            default:   nxt = ST_IDLE;
         endcase
   end
   assign sel      = line_sel(nxt);
   assign shift_en = nxt == ST_DATA;
   assign tx_d     = sel == LS_START  ? 1'b0      :
                     sel == LS_DATA   ? ser_bit   :
                     sel == LS_PARITY ? par_bit_q : IDLE_LVL;
   uart_tx_serializer #(.DATA_W(DATA_W)) u_ser (
      .CLK      (CLK),
      .RST      (RST),
      .load     (accept),
      .shift_en (shift_en),
      .din      (P_DATA),
      .bit_out  (ser_bit),
      .done     (ser_done)
   );
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         state     <= ST_IDLE;
         TX_OUT    <= IDLE_LVL;
         BUSY      <= 1'b0;
         DATA_ACK  <= 1'b0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
      end else begin
         state    <= nxt;
         TX_OUT   <= tx_d;
         BUSY     <= nxt != ST_IDLE;
         DATA_ACK <= nxt == ST_START;
         if (accept) begin
            par_en_q  <= PAR_EN;
            par_bit_q <= ^P_DATA ^ PAR_TYP;
         end
      end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed self-checking bench for uart_tx_engine (DATA_W=8 and DATA_W=7)
module tb_uart_tx_engine;
   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] p_data = '0;
   logic       dv = 1'b0, par_en = 1'b0, par_typ = 1'b0, stop2 = 1'b0, sel_r = 1'b0;
   logic       dv8, dv7, tx8, busy8, ack8, tx7, busy7, ack7, tx_s, busy_s, ack_s;
   int         n_tests = 0, n_fail = 0;
   logic [31:0] bits, ackm;
   int          len;
   always #5 CLK = ~CLK;
   assign dv8    = dv & ~sel_r;
   assign dv7    = dv & sel_r;
   assign tx_s   = sel_r ? tx7 : tx8;
   assign busy_s = sel_r ? busy7 : busy8;
   assign ack_s  = sel_r ? ack7 : ack8;
   uart_tx_engine #(.DATA_W(8)) dut8 (
      .CLK(CLK), .RST(RST), .P_DATA(p_data), .DATA_VALID(dv8), .PAR_EN(par_en),
      .PAR_TYP(par_typ), .STOP2(stop2), .TX_OUT(tx8), .BUSY(busy8), .DATA_ACK(ack8)
   );
   uart_tx_engine #(.DATA_W(7)) dut7 (
      .CLK(CLK), .RST(RST), .P_DATA(p_data[6:0]), .DATA_VALID(dv7), .PAR_EN(par_en),
      .PAR_TYP(par_typ), .STOP2(stop2), .TX_OUT(tx7), .BUSY(busy7), .DATA_ACK(ack7)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   // Sends d1 (then d2 once the first ack is seen), holds DATA_VALID until
   // 'acks' acks were observed, and records line/ack per busy cycle.
   task automatic run_frame(input logic s, input logic [7:0] d1, input logic [7:0] d2,
                            input logic pe, input logic pt, input logic st2,
                            input int acks, input logic glitch,
                            output logic [31:0] b, output logic [31:0] am, output int n);
      int   nack;
      logic done;
      sel_r = s;
      @(negedge CLK);
      p_data = d1; par_en = pe; par_typ = pt; stop2 = st2; dv = 1'b1;
      b = '0; am = '0; n = 0; nack = 0; done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge CLK);
         if (busy_s) begin
            if (n < 32) begin
               b[n]  = tx_s;
               am[n] = ack_s;
            end
            nack += int'(ack_s);
            n++;
         end else if (n > 0) done = 1'b1;
         if (nack >= 1) p_data = d2;
         if (nack >= acks) dv = glitch && (n == 4 || n == 5);
      end
      dv = 1'b0;
      chk("frame_terminated", 32'(done), 32'd1);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
   initial begin
      repeat (2) @(negedge CLK);
      chk("rst_tx8", 32'(tx8), 32'd1);
      chk("rst_busy8", 32'(busy8), 32'd0);
      chk("rst_ack8", 32'(ack8), 32'd0);
      chk("rst_tx7", 32'(tx7), 32'd1);
      chk("rst_busy7", 32'(busy7), 32'd0);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      chk("idle_tx8", 32'(tx8), 32'd1);
      // 0xA5, no parity, mid-frame DATA_VALID pulse and P_DATA change ignored
      run_frame(1'b0, 8'hA5, 8'h5A, 1'b0, 1'b0, 1'b0, 1, 1'b1, bits, ackm, len);
      chk("a5_bits", bits, 32'h34A);
      chk("a5_len", 32'(len), 32'd10);
      chk("a5_ack", ackm, 32'h1);
      chk("a5_idle_tx", 32'(tx8), 32'd1);
      // 0xA5, even parity -> parity bit 0
      run_frame(1'b0, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b0, bits, ackm, len);
      chk("a5_even_bits", bits, 32'h54A);
      chk("a5_even_len", 32'(len), 32'd11);
      // 0xA5, odd parity -> parity bit 1
      run_frame(1'b0, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, 1, 1'b0, bits, ackm, len);
      chk("a5_odd_bits", bits, 32'h74A);
      chk("a5_odd_len", 32'(len), 32'd11);
      // two stop bits requested
      run_frame(1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b0, bits, ackm, len);
`ifdef UART_TX_STOP2_EN
      chk("stop2_bits", bits, 32'h74A);
      chk("stop2_len", 32'(len), 32'd11);
`else
      chk("stop2_bits", bits, 32'h34A);
      chk("stop2_len", 32'(len), 32'd10);
`endif
      // back-to-back 0x00 then 0xFF with DATA_VALID held
      run_frame(1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 2, 1'b0, bits, ackm, len);
      chk("b2b_bits", bits, 32'hFFA00);
      chk("b2b_len", 32'(len), 32'd20);
      chk("b2b_ack", ackm, 32'h401);
      // reset during data bit 3
      sel_r = 1'b0; p_data = 8'hA5; par_en = 1'b0; stop2 = 1'b0; dv = 1'b1;
      @(negedge CLK);
      dv = 1'b0;
      chk("mid_start_ack", 32'(ack8), 32'd1);
      repeat (4) @(negedge CLK);
      chk("mid_bit3_tx", 32'(tx8), 32'd0);
      chk("mid_bit3_busy", 32'(busy8), 32'd1);
      RST = 1'b0;
      #1;
      chk("mid_rst_tx", 32'(tx8), 32'd1);
      chk("mid_rst_busy", 32'(busy8), 32'd0);
      chk("mid_rst_ack", 32'(ack8), 32'd0);
      @(negedge CLK);
      chk("rst_hold_tx", 32'(tx8), 32'd1);
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      chk("post_rst_tx", 32'(tx8), 32'd1);
      chk("post_rst_busy", 32'(busy8), 32'd0);
      run_frame(1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b0, bits, ackm, len);
      chk("post_rst_bits", bits, 32'h278);
      chk("post_rst_len", 32'(len), 32'd10);
      // DATA_W=7, 0x7F, odd parity -> parity bit 0
      run_frame(1'b1, 8'h7F, 8'h00, 1'b1, 1'b1, 1'b0, 1, 1'b0, bits, ackm, len);
      chk("w7_bits", bits, 32'h2FE);
      chk("w7_len", 32'(len), 32'd10);
      chk("w7_ack", ackm, 32'h1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter DATA_W, default 8, frame data bits per character; legal range 5..9.
REQ-002 Parameter IDLE_LVL, default 1'b1, line level driven in IDLE and STOP.
REQ-003 CLK  input  1  bit-rate clock; one TX bit per CLK cycle.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 P_DATA  input  DATA_W  parallel character to send.
REQ-006 DATA_VALID  input  1  request to send P_DATA.
REQ-007 PAR_EN  input  1  parity bit enable.
REQ-008 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 STOP2  input  1  1 = two stop bits, 0 = one stop bit.
REQ-010 TX_OUT  output  1  serial line, registered.
REQ-011 BUSY  output  1  frame in progress, registered.
REQ-012 DATA_ACK  output  1  one-cycle pulse that P_DATA was captured.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-014 In IDLE, DATA_VALID high at a CLK edge SHALL capture P_DATA, PAR_EN, PAR_TYP and STOP2, and SHALL enter START.
REQ-015 DATA_ACK SHALL be high for exactly the START cycle.
REQ-016 TX_OUT SHALL be 0 in START; data bits LSB first, one per cycle, for DATA_W cycles in DATA; parity in PARITY; IDLE_LVL in STOP1/STOP2/IDLE.
REQ-017 DATA SHALL exit after DATA_W cycles, counted by a $clog2(DATA_W+1)-bit counter, to PARITY if captured PAR_EN, else to STOP1.
REQ-018 PARITY bit SHALL be the XOR of the captured data (even), inverted when captured PAR_TYP=1 (odd), and SHALL be computed at capture.
REQ-019 STOP1 SHALL go to STOP2 if captured STOP2=1; the last stop state SHALL go to START if DATA_VALID=1 (back-to-back, no idle gap), else to IDLE.
REQ-020 BUSY SHALL be 1 in START..last stop and 0 in IDLE.
REQ-021 DATA_VALID and P_DATA changes outside IDLE/last-stop SHALL be ignored; captured values SHALL stay stable for the whole frame.
REQ-022 Frame length SHALL be 1+DATA_W+PAR_EN+(1+STOP2) cycles; first TX_OUT=0 appears one cycle after the accepting edge.

Reset
REQ-023 RST low SHALL immediately force state IDLE, TX_OUT=IDLE_LVL, BUSY=0, DATA_ACK=0, counter=0, capture registers=0.
REQ-024 Reset mid-frame SHALL abort the frame with no further line activity; the first DATA_VALID after release starts a fresh frame.

Configuration
REQ-025 Macro UART_TX_STOP2_EN defined: the STOP2 input and state are active per REQ-019.
REQ-026 Macro undefined: the STOP2 state and its capture register SHALL not be built, STOP2 input SHALL be ignored, and every frame SHALL use one stop bit.

Structure
REQ-027 Package uart_tx_pkg SHALL hold the state encoding (one-hot, 6 bits) and the line-select constants (START/DATA/PARITY/STOP).
REQ-028 Sub-module uart_tx_serializer SHALL hold the shift register and bit counter: load, shift-enable, done outputs; the FSM, parity and output register stay in uart_tx_engine.

Verification
REQ-029 DATA_W=8, 0xA5, PAR_EN=0, STOP2=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,1; BUSY high for 10 cycles; DATA_ACK high for 1 cycle.
REQ-030 0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1; frame 11 cycles.
REQ-031 0x00 then 0xFF back-to-back, DATA_VALID held high -> second START immediately follows the stop bit; BUSY never drops between frames.
REQ-032 RST low in DATA bit 3 -> TX_OUT=1, BUSY=0 in the same cycle; the next frame is correct.
REQ-033 STOP2=1, macro defined -> 2 stop cycles; macro undefined -> 1 stop cycle.
REQ-034 DATA_W=7, 0x7F, PAR_EN=1 odd -> 0,1,1,1,1,1,1,1,0,1.
